// File: rtl/rca_seq_ctrl.sv
// Two-requester sequencer sharing one SLICE-bit adder; WIDTH-bit sums are built LSB slice first, one slice per clock.
// Optional define RCA_SEQ_OVF_EN adds the res_ovf signed-overflow output.
module rca_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
`ifdef RCA_SEQ_OVF_EN
   output logic             res_ovf,
`endif
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   if ((WIDTH % SLICE) != 0 || SLICE < 2) begin : gBadParams
      $error("rca_seq_ctrl: WIDTH must be a multiple of SLICE and SLICE >= 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [WIDTH-1:0] resSum_q;
   logic [IDXW-1:0]  sliceIdx_q;
   logic             carry_q;
   logic             resCout_q;
   logic             resId_q;
   logic             resValid_q;
   logic             busy_q;
   logic             rrPtr_q;

   logic             grantValid;
   logic             grantId;
   logic [31:0]      sliceBase;
   logic [SLICE-1:0] aSlice;
   logic [SLICE-1:0] bSlice;
   logic [SLICE:0]   sliceSum;
   logic [WIDTH-1:0] resSum_d;
   logic             carry_d;

   // rrPtr_q names the requester granted last; on a tie the other one wins.
   always_comb begin
      grantValid = 1'b0;
      grantId    = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grantValid = 1'b1;
            grantId    = ~rrPtr_q;
         end else if (req0_valid) begin
            grantValid = 1'b1;
            grantId    = 1'b0;
         end else if (req1_valid) begin
            grantValid = 1'b1;
            grantId    = 1'b1;
         end
      end
   end

   assign req0_ready = grantValid && !grantId;
   assign req1_ready = grantValid && grantId;

   assign sliceBase = 32'(sliceIdx_q) * SLICE;
   assign aSlice    = opA_q[sliceBase +: SLICE];
   assign bSlice    = opB_q[sliceBase +: SLICE];
   assign sliceSum  = {1'b0, aSlice} + {1'b0, bSlice} + {{SLICE{1'b0}}, carry_q};
   assign carry_d   = sliceSum[SLICE];

   always_comb begin
      resSum_d                     = resSum_q;
      resSum_d[sliceBase +: SLICE] = sliceSum[SLICE-1:0];
   end

`ifdef RCA_SEQ_OVF_EN
   logic [SLICE-1:0] lowSum;
   logic             resOvf_d;
   logic             resOvf_q;

   // Adding only the low SLICE-1 bits exposes the carry into the slice MSB.
   assign lowSum   = {1'b0, aSlice[SLICE-2:0]} + {1'b0, bSlice[SLICE-2:0]} + {{(SLICE-1){1'b0}}, carry_q};
   assign resOvf_d = lowSum[SLICE-1] ^ carry_d;
   assign res_ovf  = resOvf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         resSum_q   <= '0;
         sliceIdx_q <= '0;
         carry_q    <= 1'b0;
         resCout_q  <= 1'b0;
         resId_q    <= 1'b0;
         resValid_q <= 1'b0;
         busy_q     <= 1'b0;
         rrPtr_q    <= 1'b1;
`ifdef RCA_SEQ_OVF_EN
         resOvf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grantValid) begin
                  opA_q      <= grantId ? req1_a : req0_a;
                  opB_q      <= grantId ? req1_b : req0_b;
                  carry_q    <= grantId ? req1_cin : req0_cin;
                  resId_q    <= grantId;
                  resSum_q   <= '0;
                  sliceIdx_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               resSum_q <= resSum_d;
               carry_q  <= carry_d;
               if (sliceIdx_q == LAST_IDX) begin
                  sliceIdx_q <= '0;
                  resCout_q  <= carry_d;
`ifdef RCA_SEQ_OVF_EN
                  resOvf_q   <= resOvf_d;
`endif
                  resValid_q <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  sliceIdx_q <= sliceIdx_q + IDXW'(1);
               end
            end
            DONE: begin
               if (res_ready) begin
                  resValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  rrPtr_q    <= resId_q;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res_valid = resValid_q;
   assign res_sum   = resSum_q;
   assign res_cout  = resCout_q;
   assign res_id    = resId_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl (WIDTH=16, SLICE=4).
// Define RCA_SEQ_OVF_EN for both files to also check res_ovf.
module tb_rca_seq_ctrl;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;

   logic             clk;
   logic             rst;
   logic             req0_valid, req0_ready, req0_cin;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_cin;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             res_valid, res_ready, res_cout, res_id, busy;
   logic [WIDTH-1:0] res_sum;
`ifdef RCA_SEQ_OVF_EN
   logic             res_ovf;
`endif

   int checkCount = 0;
   int passCount  = 0;

   rca_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id),
`ifdef RCA_SEQ_OVF_EN
      .res_ovf    (res_ovf),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Presents one operation from the idle state, checks the grant, and returns one edge after acceptance.
   task automatic applyStimulus(input string tag, input logic id, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin);
      if (id) begin
         req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
      end
      #1;
      checkOutput({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
      nextCycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a = '1; req0_b = '1; req1_a = '1; req1_b = '1;
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic waitResult(input string tag);
      int lat;
      lat = 0;
      while (!res_valid && lat < 20) begin
         nextCycle();
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, 32'd4);
   endtask

   task automatic runOp(input string tag, input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] expSum, input logic expCout);
      res_ready = 1'b1;
      applyStimulus(tag, id, a, b, cin);
      waitResult(tag);
      checkOutput({tag, "_sum"}, {16'd0, res_sum}, {16'd0, expSum});
      checkOutput({tag, "_cout"}, {31'd0, res_cout}, {31'd0, expCout});
      checkOutput({tag, "_id"}, {31'd0, res_id}, {31'd0, id});
      nextCycle();
      checkOutput({tag, "_validLow"}, {31'd0, res_valid}, 32'd0);
      checkOutput({tag, "_busyLow"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int grantId[8];
      int grantCyc[8];
      int grantCount;
      logic sawValid;

      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      res_ready = 1'b0;
      repeat (2) nextCycle();
      checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("rst_sum", {16'd0, res_sum}, 32'd0);
      checkOutput("rst_cout", {31'd0, res_cout}, 32'd0);
      checkOutput("rst_id", {31'd0, res_id}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      rst = 1'b0;
      nextCycle();

      runOp("t1", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      runOp("t2a", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      runOp("t2b", 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

      // Consumer stalls in DONE while both requesters wait.
      res_ready = 1'b0;
      applyStimulus("t4", 1'b0, 16'hABCD, 16'h1111, 1'b1);
      waitResult("t4");
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         checkOutput("t4_holdValid", {31'd0, res_valid}, 32'd1);
         checkOutput("t4_holdSum", {16'd0, res_sum}, 32'h0000BCDF);
         checkOutput("t4_holdReady", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      res_ready = 1'b1;
      nextCycle();
      checkOutput("t4_validLow", {31'd0, res_valid}, 32'd0);
      checkOutput("t4_busyLow", {31'd0, busy}, 32'd0);
      checkOutput("t4_rrGrant", {30'd0, req1_ready, req0_ready}, 32'd2);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nextCycle();

      // Back-to-back arbitration from a fresh reset.
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
      req1_a = 16'h1000; req1_b = 16'h2000; req1_cin = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      grantCount = 0;
      for (int cyc = 0; cyc < 26; cyc++) begin
         #1;
         if ((req0_ready || req1_ready) && grantCount < 8) begin
            grantId[grantCount]  = req1_ready ? 1 : 0;
            grantCyc[grantCount] = cyc;
            grantCount++;
         end
         @(posedge clk);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("t3_grantCount", grantCount, 32'd5);
      if (grantCount >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_grant%0d", i), grantId[i], i % 2);
            if (i > 0) checkOutput($sformatf("t3_interval%0d", i), grantCyc[i] - grantCyc[i-1], 32'd6);
         end
      end
      repeat (8) nextCycle();

      // Reset pulsed while the third slice is pending.
      applyStimulus("t5", 1'b1, 16'h1111, 16'h1111, 1'b0);
      nextCycle();
      nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("t5_sum", {16'd0, res_sum}, 32'd0);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("t5_id", {31'd0, res_id}, 32'd0);
      checkOutput("t5_cout", {31'd0, res_cout}, 32'd0);
      nextCycle();
      rst = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         if (res_valid) sawValid = 1'b1;
      end
      checkOutput("t5_noResult", {31'd0, sawValid}, 32'd0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checkOutput("t5_firstGrant", {30'd0, req1_ready, req0_ready}, 32'd1);
      nextCycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (8) nextCycle();

      // Signed-overflow corner cases; the unsigned results are checked in every build.
      res_ready = 1'b0;
      applyStimulus("t6a", 1'b0, 16'h7FFF, 16'h0001, 1'b0);
      waitResult("t6a");
      checkOutput("t6a_sum", {16'd0, res_sum}, 32'h00008000);
      checkOutput("t6a_cout", {31'd0, res_cout}, 32'd0);
`ifdef RCA_SEQ_OVF_EN
      checkOutput("t6a_ovf", {31'd0, res_ovf}, 32'd1);
`endif
      res_ready = 1'b1;
      nextCycle();
      runOp("t6b", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      res_ready = 1'b0;
      applyStimulus("t6c", 1'b0, 16'h8000, 16'h8000, 1'b0);
      waitResult("t6c");
      checkOutput("t6c_sum", {16'd0, res_sum}, 32'd0);
      checkOutput("t6c_cout", {31'd0, res_cout}, 32'd1);
`ifdef RCA_SEQ_OVF_EN
      checkOutput("t6c_ovf", {31'd0, res_ovf}, 32'd1);
`endif
      res_ready = 1'b1;
      nextCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Sequencer/arbiter that shares one SLICE-bit ripple-carry adder slice between two requesters. Wide WIDTH-bit additions are performed serially, one slice per clock, LSB slice first. The carry is registered between slices. Sits between operand producers and a result consumer, using valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width; must be an integer multiple of SLICE
SLICE, 4, bits added per cycle (width of shared adder slice); NSLICE = WIDTH/SLICE

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has operands
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_cin  input  1  requester 0 carry-in
req1_valid  input  1  requester 1 has operands
req1_ready  output  1  requester 1 accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_cin  input  1  requester 1 carry-in
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_sum  output  WIDTH  A+B+cin, low WIDTH bits
res_cout  output  1  carry out of MSB
res_id  output  1  requester that owns the result
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state IDLE, req0_ready=0, req1_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, slice index=0, carry reg=0, round-robin pointer=1 (req0 wins first).
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester not granted last.
  - reqN_ready is combinational: high only in IDLE for the granted requester.
  - On the handshake edge: latch a, b, cin and id. Set carry reg = cin, slice index = 0, res_sum = 0. Go to RUN.
  - No grant when neither requester is valid.
- RUN, each edge:
  - {c, s} = a[k] + b[k] + carry, where k = slice index.
  - Write s into res_sum[k*SLICE +: SLICE]; carry <= c; k <= k+1.
  - After slice NSLICE-1: res_cout <= c, go to DONE.
  - RUN always lasts exactly NSLICE cycles.
- DONE:
  - res_valid=1; res_sum/res_cout/res_id held stable.
  - On res_valid && res_ready: go to IDLE, pointer <= res_id.
  - res_ready low: hold indefinitely; no new grants.
- Latency: res_valid rises NSLICE cycles after the accept edge. Minimum issue interval is NSLICE+2 cycles, since one IDLE cycle is required between operations.
- req ready stays 0 whenever the state is not IDLE. Operand changes after acceptance have no effect.
- res_sum is partial during RUN and must only be consumed while res_valid is high.
- Reset mid-operation clears everything immediately. The in-flight result is discarded and no res_valid is produced for it.
- Wrap-around: the sum is truncated to WIDTH bits; overflow is visible only via res_cout (and res_ovf when enabled).

Optional Feature:
- Macro RCA_SEQ_OVF_EN.
- Defined: adds output port res_ovf (1 bit, reset 0), the signed two's-complement overflow of the result. res_ovf = (carry into MSB) XOR (carry out of MSB), captured in the final RUN slice and held in DONE with the other result fields.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=16/SLICE=4. req0: a=0x1234, b=0x4321, cin=0 -> res_sum=0x5555, res_cout=0, res_id=0; res_valid high 4 cycles after the accept edge.
2. req1: a=0xFFFF, b=0x0001, cin=0 -> res_sum=0x0000, res_cout=1, res_id=1 (carry ripples through all 4 slices). Also req1: a=0x0000, b=0x0000, cin=1 -> res_sum=0x0001.
3. Both valid continuously with res_ready=1 -> grants alternate 0,1,0,1; first grant is 0 after reset; each issue interval is 6 cycles.
4. res_ready held 0 for 5 cycles in DONE -> res_valid stays 1, result stable, req0_ready=req1_ready=0; then res_ready=1 -> IDLE on the next edge.
5. rst pulsed during RUN (k=2) -> all outputs 0 immediately, no res_valid for that op. After release, both requesters valid -> req0 granted.
6. With RCA_SEQ_OVF_EN: 0x7FFF+0x0001 -> res_ovf=1, res_cout=0; 0xFFFF+0x0001 -> res_ovf=0, res_cout=1; 0x8000+0x8000 -> res_ovf=1, res_sum=0x0000.
